// File: rtl/yrv_mem_resp_if.sv
// Pipelined CPU memory bus: address/control phase followed by a data phase
// that completes on the edge where mem_ready is high.
interface yrv_mem_resp_if;
    logic [31:0] mem_addr;
    logic [3:0]  mem_ble;
    logic        mem_lock;
    logic [1:0]  mem_trans;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        acc_err;

    modport master (
        output mem_addr, mem_ble, mem_lock, mem_trans, mem_write, mem_wdata,
        input  mem_rdata, mem_ready, acc_err
    );

    modport slave (
        input  mem_addr, mem_ble, mem_lock, mem_trans, mem_write, mem_wdata,
        output mem_rdata, mem_ready, acc_err
    );
endinterface

// File: rtl/yrv_mem_resp.sv
// Memory-side responder for the core's pipelined bus, backed by a byte-writable
// 32-bit RAM with programmable read/write wait states and an address window.
module yrv_mem_resp #(
    parameter int          ADDR_W  = 12,
    parameter logic [31:0] BASE    = 32'h0000_0000,
    parameter int          WAIT_RD = 0,
    parameter int          WAIT_WR = 0
) (
    input  logic         clk,
    input  logic         resetb,
    yrv_mem_resp_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_LAST = 2'd2;

    localparam logic [3:0] WAIT_RD_L = 4'(WAIT_RD);
    localparam logic [3:0] WAIT_WR_L = 4'(WAIT_WR);

    logic [1:0]        state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              dp_valid_reg;
    logic              dp_write_reg;
    logic              dp_inwin_reg;
    logic [ADDR_W-1:0] dp_idx_reg;
    logic [3:0]        dp_ble_reg;
    logic              acc_err_reg;

    logic              capture;
    logic              complete;
    logic              cap_write;
    logic              cap_inwin;
    logic [ADDR_W-1:0] cap_idx;
    logic [3:0]        cap_wait;
    logic              ram_we;
    logic              out_en;

    // Lock is meaningless with a single master; byte offset bits never select lanes.
    logic unused_bits;
    assign unused_bits = ^{bus.mem_lock, bus.mem_addr[1:0], BASE[ADDR_W+1:0]};

    assign bus.mem_ready = (state_reg != ST_DATA);
    assign complete      = (state_reg == ST_LAST) && dp_valid_reg;

    // Transfer types 01 and 11 both have bit 0 set; 00 and reserved 10 do not.
    assign capture   = bus.mem_ready && bus.mem_trans[0];
    assign cap_write = bus.mem_write && !bus.mem_trans[1];
    assign cap_inwin = (bus.mem_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
    assign cap_idx   = bus.mem_addr[ADDR_W+1:2];
    assign cap_wait  = cap_write ? WAIT_WR_L : WAIT_RD_L;

    assign ram_we = complete && dp_write_reg && dp_inwin_reg;
    assign out_en = (state_reg != ST_IDLE) && dp_valid_reg && !dp_write_reg && dp_inwin_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE, ST_LAST: begin
                if (capture) begin
                    cnt_next   = cap_wait;
                    state_next = (cap_wait == 4'd0) ? ST_LAST : ST_DATA;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = ST_LAST;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            dp_valid_reg <= 1'b0;
            dp_write_reg <= 1'b0;
            dp_inwin_reg <= 1'b0;
            dp_idx_reg   <= '0;
            dp_ble_reg   <= 4'd0;
            acc_err_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            acc_err_reg <= complete && !dp_inwin_reg;
            if (capture) begin
                dp_valid_reg <= 1'b1;
                dp_write_reg <= cap_write;
                dp_inwin_reg <= cap_inwin;
                dp_idx_reg   <= cap_idx;
                dp_ble_reg   <= bus.mem_ble;
            end else if (complete) begin
                dp_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.acc_err = acc_err_reg;

    // One byte-wide RAM per lane; the read register and the bypass capture are
    // both loaded only at the capture edge so the word holds through wait states.
    // A write completing on that same edge is merged after the RAM register,
    // keeping the RAM itself a plain read-old-data block.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] q_reg;
        logic [7:0] byp_data_reg;
        logic       byp_en_reg;

        always_ff @(posedge clk) begin
            if (ram_we && dp_ble_reg[gi]) begin
                mem[dp_idx_reg] <= bus.mem_wdata[8*gi +: 8];
            end
            if (capture) begin
                q_reg        <= mem[cap_idx];
                byp_data_reg <= bus.mem_wdata[8*gi +: 8];
                byp_en_reg   <= ram_we && dp_ble_reg[gi] && (dp_idx_reg == cap_idx);
            end
        end

        assign bus.mem_rdata[8*gi +: 8] = !out_en    ? 8'h00 :
                                          byp_en_reg ? byp_data_reg : q_reg;
    end
endmodule

// File: tb/tb_yrv_mem_resp.sv
// Directed plus random bench for yrv_mem_resp against a transaction-level model
// of the bus (per-transfer wait budget, write-then-read RAM semantics).
module tb_yrv_mem_resp;
    localparam int          ADDR_W  = 12;
    localparam logic [31:0] BASE    = 32'h0001_0000;
    localparam int          WAIT_RD = 2;
    localparam int          WAIT_WR = 1;
    localparam int          DEPTH   = 1 << ADDR_W;

    logic clk    = 1'b0;
    logic resetb = 1'b1;
    always #5 clk = ~clk;

    yrv_mem_resp_if bus ();

    yrv_mem_resp #(
        .ADDR_W (ADDR_W),
        .BASE   (BASE),
        .WAIT_RD(WAIT_RD),
        .WAIT_WR(WAIT_WR)
    ) dut (
        .clk   (clk),
        .resetb(resetb),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int low_cnt  = 0;
    int acc_cnt  = 0;

    // Reference model: RAM image plus the one outstanding data phase.
    logic [31:0]       ram_m [DEPTH];
    logic              p_valid = 1'b0;
    logic              p_write = 1'b0;
    logic              p_inwin = 1'b0;
    logic [ADDR_W-1:0] p_idx   = '0;
    logic [3:0]        p_ble   = 4'h0;
    logic [31:0]       p_wdata = 32'h0;
    logic [31:0]       p_rdata = 32'h0;
    int                p_wait  = 0;
    logic              acc_exp = 1'b0;
    logic              accepted;
    logic [31:0]       next_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic              completing;
        logic              cap;
        logic              cap_write;
        logic              cap_in;
        logic [ADDR_W-1:0] cap_idx;
        logic [3:0]        cap_ble;
        logic              exp_ready;
        logic [31:0]       exp_rdata;
        completing = p_valid && (p_wait == 0);
        cap        = (!p_valid || p_wait == 0) && (bus.mem_trans == 2'b01 || bus.mem_trans == 2'b11);
        cap_write  = bus.mem_write && (bus.mem_trans == 2'b01);
        cap_in     = (bus.mem_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
        cap_idx    = bus.mem_addr[ADDR_W+1:2];
        cap_ble    = bus.mem_ble;
        bus.mem_wdata = (p_valid && p_write) ? p_wdata : $urandom;
        @(posedge clk);
        accepted = cap;
        if (completing && p_write && p_inwin) begin
            for (int b = 0; b < 4; b++) begin
                if (p_ble[b]) ram_m[p_idx][8*b +: 8] = p_wdata[8*b +: 8];
            end
        end
        acc_exp = completing && !p_inwin;
        if (cap) begin
            p_valid = 1'b1;
            p_write = cap_write;
            p_inwin = cap_in;
            p_idx   = cap_idx;
            p_ble   = cap_ble;
            p_wdata = next_wdata;
            p_rdata = ram_m[cap_idx];
            p_wait  = cap_write ? WAIT_WR : WAIT_RD;
        end else if (completing) begin
            p_valid = 1'b0;
        end else if (p_valid) begin
            p_wait--;
        end
        #1;
        exp_ready = !p_valid || (p_wait == 0);
        exp_rdata = (p_valid && !p_write && p_inwin) ? p_rdata : 32'h0;
        chk("mem_ready", {31'b0, bus.mem_ready}, {31'b0, exp_ready});
        chk("mem_rdata", bus.mem_rdata, exp_rdata);
        chk("acc_err", {31'b0, bus.acc_err}, {31'b0, acc_exp});
        if (bus.mem_ready === 1'b0) low_cnt++;
        if (bus.acc_err === 1'b1) acc_cnt++;
    endtask

    task automatic issue(input logic [1:0] tr, input logic [31:0] a, input logic [3:0] ble,
                         input logic w, input logic [31:0] wd);
        int n;
        bus.mem_trans = tr;
        bus.mem_addr  = a;
        bus.mem_ble   = ble;
        bus.mem_write = w;
        bus.mem_lock  = 1'($urandom);
        next_wdata    = wd;
        n = 0;
        if (tr[0]) begin
            do begin
                tick();
                n++;
            end while (!accepted && n < 40);
            chk("accept", {31'b0, accepted}, 32'd1);
        end else begin
            tick();
        end
        bus.mem_trans = 2'b00;
        bus.mem_addr  = $urandom;
        bus.mem_write = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.mem_trans = 2'b00;
        while (p_valid && n < 40) begin
            tick();
            n++;
        end
        chk("drain", {31'b0, p_valid}, 32'd0);
    endtask

    function automatic logic [31:0] waddr(input int idx);
        return BASE + 32'(idx << 2);
    endfunction

    int          idx_set [10];
    int          k;
    logic [31:0] a;
    logic [31:0] oob;

    initial begin
        bus.mem_addr  = 32'h0;
        bus.mem_ble   = 4'h0;
        bus.mem_lock  = 1'b0;
        bus.mem_trans = 2'b00;
        bus.mem_write = 1'b0;
        bus.mem_wdata = 32'h0;
        next_wdata    = 32'h0;
        accepted      = 1'b0;
        for (int i = 0; i < 8; i++) idx_set[i] = i;
        idx_set[8] = DEPTH - 2;
        idx_set[9] = DEPTH - 1;
        oob = BASE + 32'(4 << ADDR_W);

        // Reset values, sampled between clock edges.
        #1 resetb = 1'b0;
        #1;
        chk("rst_ready", {31'b0, bus.mem_ready}, 32'd1);
        chk("rst_rdata", bus.mem_rdata, 32'h0);
        chk("rst_acc_err", {31'b0, bus.acc_err}, 32'd0);
        #10 resetb = 1'b1;
        @(posedge clk);
        #1;

        // Preload every word the rest of the run reads.
        for (int i = 0; i < 10; i++) begin
            issue(2'b01, waddr(idx_set[i]), 4'hF, 1'b1, $urandom);
        end
        drain();

        // Full-word write followed back-to-back by a read: bypass path.
        issue(2'b01, waddr(4), 4'hF, 1'b1, 32'hDEADBEEF);
        issue(2'b01, waddr(4), 4'hF, 1'b0, 32'h0);
        chk("bypass", bus.mem_rdata, 32'hDEADBEEF);
        drain();

        // Single-lane write over an existing word.
        issue(2'b01, waddr(5), 4'hF, 1'b1, 32'h11223344);
        issue(2'b01, waddr(5), 4'b0100, 1'b1, 32'h00AA0000);
        drain();
        issue(2'b01, waddr(5) | 32'h3, 4'hF, 1'b0, 32'h0);
        chk("lane_merge", bus.mem_rdata, 32'h11AA3344);
        drain();

        // Wait-state lengths.
        low_cnt = 0;
        issue(2'b01, waddr(6), 4'hF, 1'b0, 32'h0);
        drain();
        chk("rd_wait_cycles", 32'(low_cnt), 32'(WAIT_RD));
        low_cnt = 0;
        issue(2'b01, waddr(6), 4'hF, 1'b1, 32'hCAFEF00D);
        drain();
        chk("wr_wait_cycles", 32'(low_cnt), 32'(WAIT_WR));
        issue(2'b01, waddr(6), 4'hF, 1'b0, 32'h0);
        chk("wr_then_rd", bus.mem_rdata, 32'hCAFEF00D);
        drain();

        // Out-of-window read and write (aliases index 0 but must not touch it).
        acc_cnt = 0;
        issue(2'b01, oob, 4'hF, 1'b0, 32'h0);
        drain();
        chk("oob_rd_pulses", 32'(acc_cnt), 32'd1);
        acc_cnt = 0;
        issue(2'b01, oob, 4'hF, 1'b1, 32'h5A5A5A5A);
        drain();
        chk("oob_wr_pulses", 32'(acc_cnt), 32'd1);
        issue(2'b01, waddr(0), 4'hF, 1'b0, 32'h0);
        chk("oob_alias", bus.mem_rdata, ram_m[0]);
        drain();

        // Reset asserted during a write wait state.
        issue(2'b01, waddr(7), 4'hF, 1'b1, 32'h0BADC0DE);
        resetb = 1'b0;
        #1;
        p_valid = 1'b0;
        acc_exp = 1'b0;
        chk("midrst_ready", {31'b0, bus.mem_ready}, 32'd1);
        chk("midrst_rdata", bus.mem_rdata, 32'h0);
        chk("midrst_acc_err", {31'b0, bus.acc_err}, 32'd0);
        #1 resetb = 1'b1;
        issue(2'b01, waddr(7), 4'hF, 1'b0, 32'h0);
        chk("midrst_prior", bus.mem_rdata, ram_m[7]);
        drain();

        // Fetch with write set reads; reserved type never captures.
        issue(2'b11, waddr(3), 4'hF, 1'b1, 32'hFFFF0000);
        drain();
        issue(2'b01, waddr(3), 4'hF, 1'b0, 32'h0);
        chk("fetch_no_write", bus.mem_rdata, ram_m[3]);
        drain();
        issue(2'b10, waddr(3), 4'hF, 1'b0, 32'h0);
        chk("reserved_ready", {31'b0, bus.mem_ready}, 32'd1);
        chk("reserved_rdata", bus.mem_rdata, 32'h0);

        // Wrap: top index straight into index 0.
        issue(2'b01, waddr(DEPTH - 1), 4'hF, 1'b0, 32'h0);
        issue(2'b01, waddr(0), 4'hF, 1'b0, 32'h0);
        chk("wrap_idx0", bus.mem_rdata, ram_m[0]);
        drain();

        // Random mix of types, lanes, windows and idle gaps.
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            a = waddr(idx_set[k]) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3) << (ADDR_W + 2));
            issue(2'($urandom_range(0, 3)), a, 4'($urandom), 1'($urandom), $urandom);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/yrv_mem_resp.md
# yrv_mem_resp

Memory-side responder for the core's pipelined memory bus: it accepts address/control phases from the CPU, completes data phases with `mem_ready`, and backs them with an internal byte-writable 32-bit RAM. It sits between the core and on-chip program/data storage, with programmable read and write wait states and an address window. Out-of-window accesses complete but are flagged.

## Interface
- `ADDR_W`, 12: word-address bits; RAM holds 2^ADDR_W words (16 KB default).
- `BASE`, 32'h0000_0000: window base; bits [ADDR_W+1:0] must be zero.
- `WAIT_RD`, 0: wait states per read data phase (0–15).
- `WAIT_WR`, 0: wait states per write data phase (0–15).

- `clk`  in  1  clock; all state changes on rising edge.
- `resetb`  in  1  reset; asynchronous, active-low.
- `mem_addr`  in  32  byte address, address phase.
- `mem_ble`  in  4  byte-lane enables, address phase; bit n = byte [8n+7:8n].
- `mem_lock`  in  1  locked RMW indicator; accepted, no effect (single master).
- `mem_trans`  in  2  transfer type: 00 idle, 01 data, 10 reserved (treated as idle), 11 fetch.
- `mem_write`  in  1  write when 1, address phase; ignored for fetch.
- `mem_wdata`  in  32  write data, data phase.
- `mem_rdata`  out  32  read data, data phase.
- `mem_ready`  out  1  data phase completes on the edge where this is 1.
- `acc_err`  out  1  one-cycle pulse: out-of-window transfer completed.

## Operation
- Address phase captured on a rising edge where `mem_ready`=1 and `mem_trans` is 01 or 11. Captured into a data-phase register: word address, ble, write (forced 0 for fetch), in-window flag, valid.
- In-window: `mem_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]`; word index `mem_addr[ADDR_W+1:2]`. `mem_addr[1:0]` ignored; lanes come only from `mem_ble`.
- States: IDLE (no data phase pending), DATA (pending, wait counter >0), LAST (pending, counter =0, `mem_ready`=1). Capture loads counter with WAIT_RD or WAIT_WR and enters DATA, or LAST if the value is 0. DATA decrements each cycle; reaching 0 enters LAST. At LAST's edge: new capture (back-to-back), else IDLE.
- `mem_ready` = 0 only in DATA; 1 in IDLE and LAST.
- Reads: RAM read synchronously at the capture edge; output register holds the word through the wait states.
- Writes: at the completing edge, in-window writes update only the enabled lanes with `mem_wdata`. Out-of-window writes are dropped.
- Bypass: if a read is captured on the same edge as an in-window write completes to the same word, enabled write lanes are forwarded into the read data. Other lanes come from RAM.
- `mem_rdata` = RAM/bypass word during in-window read/fetch data phases; 32'h0 otherwise, including out-of-window reads, writes and IDLE.
- `acc_err` = 1 for the cycle after any out-of-window data phase completes; always 0 on in-window transfers.
- `mem_trans`, `mem_addr`, ble and write are sampled only at capture edges; changes during DATA are ignored.

## Timing
- Reset (async assert, sync-safe release): state IDLE, counter 0, `mem_ready`=1, `mem_rdata`=0, `acc_err`=0, data-phase valid=0. RAM contents not reset.
- Zero-wait: address at edge N, data phase cycle N..N+1, completes edge N+1; back-to-back transfers each take one cycle.
- W wait states: `mem_ready` low for W cycles after capture; completes edge N+1+W.
- Reset mid-transfer: pending write discarded (RAM unchanged); pending read abandoned; bus returns to IDLE with `mem_ready`=1.
- Idle between transfers: no RAM write, `mem_rdata`=0.
- Address wrap: highest word index followed by index 0 is ordinary; no wrap logic.

## Test plan
- Zero-wait write 32'hDEADBEEF, ble 4'hF, to BASE+0x10, then read it back-to-back -> read data phase returns 32'hDEADBEEF via bypass, `mem_ready` never low.
- Byte-lane write 32'h00AA0000, ble 4'b0100, over 32'h11223344 -> read returns 32'h11AA3344.
- WAIT_RD=2, WAIT_WR=1: read -> `mem_ready` low exactly 2 cycles, data stable throughout. Write -> low 1 cycle, RAM updated only at the completing edge.
- Read at BASE+(4<<ADDR_W) -> `mem_rdata`=0, `acc_err` pulses one cycle. Write there -> RAM unchanged at aliased index 0.
- Assert `resetb` low during a write wait state -> `mem_ready`=1, outputs 0 immediately. Subsequent read of that word shows its prior value.
- Fetch (`mem_trans`=11) with `mem_write`=1 -> treated as read, RAM not written. `mem_trans`=10 -> no capture, `mem_ready` stays 1.
